z88_mem_sched: RTL and testbench
================================

# z88_mem_sched

Memory-slot scheduler that time-shares the single external RAM/ROM port between the LCD fetch engine and the Z80 bus. It generates the `clk_ena` / `bus_ph` slot timing consumed by the screen and CPU logic, grants one memory access per slot, and stretches a slot when the memory is slow. It sits between the Z80 glue, the LCD screen fetcher and the SRAM/flash controller.

## Interface
Parameters:
- `CLK_DIV`, 4: master clocks per bus slot. Legal range 4..16.

Ports:
- `clk` in 1: master clock, 50 MHz.
- `rst_n` in 1: asynchronous, active-low reset. The block has one clock; reset is asynchronous and active-low.
- `clk_ena` out 1: one-`clk` pulse that ends each slot.
- `bus_ph` out 1: slot owner (0: LCD, 1: Z80). Toggles on `clk_ena`.
- `lcd_rden` in 1: LCD fetch engine is running.
- `lcd_addr` in 22: LCD byte address. Valid while `bus_ph`=0.
- `lcd_vld` out 1: one-cycle pulse; `lcd_rdata` is valid.
- `lcd_rdata` out 8: LCD read data.
- `z80_req` in 1: Z80 access request. Held high until `z80_ack`.
- `z80_we` in 1: 1 means write.
- `z80_addr` in 22: Z80 physical byte address.
- `z80_wdata` in 8: Z80 write data.
- `z80_ack` out 1: one-cycle completion pulse; read data is valid.
- `z80_rdata` out 8: Z80 read data.
- `z80_wait` out 1: `z80_req` & ~`z80_ack`.
- `mem_req` out 1: memory request. Level-held until acknowledged.
- `mem_we` out 1: memory write strobe qualifier.
- `mem_addr` out 22: memory address.
- `mem_wdata` out 8: memory write data.
- `mem_ack` in 1: memory completion. Read data is valid in the same cycle.
- `mem_rdata` in 8: memory read data.

## Operation
- Slot counter `s` runs 0..`CLK_DIV`-1.
  - It increments every `clk`, except that it holds at `CLK_DIV`-1 while the FSM is not IDLE.
  - It wraps to 0 after `clk_ena`.
- `clk_ena` = (`s`==`CLK_DIV`-1) & (FSM==IDLE). `bus_ph` toggles on the same edge.
- Owner request at `s`==0: `lcd_rden` when `bus_ph`=0; `z80_req` when `bus_ph`=1.
- FSM states:
  - IDLE: at `s`==0 with an owner request, latch address, write data and we, then go to ACC. Otherwise stay in IDLE; the slot passes unused.
  - ACC: `mem_req`=1. On `mem_ack`, capture `mem_rdata` into the owner's rdata register and go to DONE.
  - DONE: pulse `lcd_vld` or `z80_ack` according to the latched owner, then go to IDLE.
- Requests arriving after `s`==0 wait for the owner's next slot. A Z80 request raised during an LCD slot is serviced in the next Z80 slot, with `z80_wait` high throughout.
- LCD writes never occur; `mem_we`=0 for LCD accesses.
- `lcd_rdata` and `z80_rdata` hold their last captured value. For Z80 writes, `z80_rdata` is unchanged.
- `mem_ack` while not in ACC is ignored.

## Timing
- Reset values:
  - `clk_ena`, `bus_ph`, `lcd_vld`, `z80_ack`, `mem_req`, `mem_we` = 0.
  - `mem_addr`, `mem_wdata`, `lcd_rdata`, `z80_rdata` = 0.
  - `s`=0, FSM=IDLE.
- `z80_wait` is combinational and equals `z80_req` during reset.
- Zero-wait memory (`mem_ack` in the first ACC cycle):
  - `s`=1: `mem_req` high.
  - `s`=2: vld/ack pulse.
  - `s`=3: `clk_ena`.
  - Slot length is exactly `CLK_DIV`.
- N wait cycles on `mem_ack` extend the slot by max(0, N-(`CLK_DIV`-4)) clocks. `clk_ena` always follows the vld/ack pulse by ≥1 clock.
- `mem_req` drops on the clock after `mem_ack` is sampled.
- `mem_addr`, `mem_we` and `mem_wdata` are stable from `mem_req` rise until the DONE cycle.
- Reset asserted mid-access: everything clears immediately and asynchronously. `mem_req` drops, and no vld/ack pulse is issued.

## Configuration
- `Z80_SLOT_RECLAIM_EN` defined: an LCD slot (`bus_ph`=0) with `lcd_rden`=0 at `s`==0 is granted to a pending `z80_req`. `bus_ph` still toggles normally.
- `Z80_SLOT_RECLAIM_EN` undefined: the Z80 accesses memory only in `bus_ph`=1 slots, and idle LCD slots are wasted.

## Test plan
- Reset release, no requests, `CLK_DIV`=4 → `clk_ena` pulses every 4 clocks; `bus_ph` toggles 0→1→0; `mem_req` is never asserted.
- `lcd_rden`=1, `lcd_addr`=22'h012345, `mem_ack` tied high with `mem_rdata`=8'hA5 → `mem_addr`=22'h012345 with `mem_req` at `s`=1; `lcd_vld` at `s`=2 with `lcd_rdata`=8'hA5; `clk_ena` at `s`=3.
- Z80 write, `z80_addr`=22'h000100, `z80_wdata`=8'h3C, `mem_ack` delayed 5 cycles → `mem_we`=1 and `mem_wdata`=8'h3C held for the whole access; slot stretched to 8 clocks; single `z80_ack`; `z80_wait` high until then.
- `z80_req` raised at `s`=2 of an LCD slot → no grant in that slot; access starts at `s`=1 of the next Z80 slot; `z80_rdata` = `mem_rdata` at the ack.
- `rst_n` pulsed low while `mem_req`=1 → `mem_req` is 0 immediately; no `lcd_vld` or `z80_ack`; after release `bus_ph`=0 and `s` restarts at 0.
- With `Z80_SLOT_RECLAIM_EN` defined, `lcd_rden`=0 and `z80_req`=1 → access is granted in the `bus_ph`=0 slot. Without the macro → access waits for `bus_ph`=1.

Source files
------------

// File: rtl/z88_mem_sched_if.sv
// Bus bundle for z88_mem_sched: slot timing, LCD fetch port, Z80 port, memory port.
// master = the scheduler, slave = the clients and memory controller around it.
interface z88_mem_sched_if;
  logic        clk_ena;
  logic        bus_ph;
  logic        lcd_rden;
  logic [21:0] lcd_addr;
  logic        lcd_vld;
  logic [7:0]  lcd_rdata;
  logic        z80_req;
  logic        z80_we;
  logic [21:0] z80_addr;
  logic [7:0]  z80_wdata;
  logic        z80_ack;
  logic [7:0]  z80_rdata;
  logic        z80_wait;
  logic        mem_req;
  logic        mem_we;
  logic [21:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  modport master (
    output clk_ena, bus_ph, lcd_vld, lcd_rdata, z80_ack, z80_rdata, z80_wait,
           mem_req, mem_we, mem_addr, mem_wdata,
    input  lcd_rden, lcd_addr, z80_req, z80_we, z80_addr, z80_wdata,
           mem_ack, mem_rdata
  );

  modport slave (
    input  clk_ena, bus_ph, lcd_vld, lcd_rdata, z80_ack, z80_rdata, z80_wait,
           mem_req, mem_we, mem_addr, mem_wdata,
    output lcd_rden, lcd_addr, z80_req, z80_we, z80_addr, z80_wdata,
           mem_ack, mem_rdata
  );
endinterface

// File: rtl/z88_mem_sched.sv
// Memory-slot scheduler sharing one RAM/ROM port between LCD fetch and Z80.
// Optional: define Z80_SLOT_RECLAIM_EN to hand idle LCD slots to a pending Z80 request.
module z88_mem_sched #(
  parameter int CLK_DIV = 4
) (
  input logic             clk,
  input logic             rst_n,
  z88_mem_sched_if.master bus
);
  localparam int              SW     = $clog2(CLK_DIV);
  localparam logic [SW-1:0]   S_LAST = SW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t        state;
  logic [SW-1:0] s;
  logic          bus_ph_q;
  logic          owner_z80;
  logic          lcd_grant;
  logic          z80_grant;
  logic          clk_ena;
  logic          lcd_vld_q;
  logic [7:0]    lcd_rdata_q;
  logic          z80_ack_q;
  logic [7:0]    z80_rdata_q;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [21:0]   mem_addr_q;
  logic [7:0]    mem_wdata_q;

  always_comb begin
    lcd_grant = ~bus_ph_q & bus.lcd_rden;
`ifdef Z80_SLOT_RECLAIM_EN
    z80_grant = bus.z80_req & (bus_ph_q | ~bus.lcd_rden);
`else
    z80_grant = bus.z80_req & bus_ph_q;
`endif
  end

  // Slot end is held off while an access is still in flight; that is the stretch.
  assign clk_ena = (s == S_LAST) && (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s        <= '0;
      bus_ph_q <= 1'b0;
    end else if (clk_ena) begin
      s        <= '0;
      bus_ph_q <= ~bus_ph_q;
    end else if (s != S_LAST) begin
      s <= s + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner_z80   <= 1'b0;
      lcd_vld_q   <= 1'b0;
      lcd_rdata_q <= '0;
      z80_ack_q   <= 1'b0;
      z80_rdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      lcd_vld_q <= 1'b0;
      z80_ack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (s == '0 && (lcd_grant || z80_grant)) begin
            owner_z80 <= ~lcd_grant;
            mem_req_q <= 1'b1;
            if (lcd_grant) begin
              mem_addr_q <= bus.lcd_addr;
              mem_we_q   <= 1'b0;
            end else begin
              mem_addr_q  <= bus.z80_addr;
              mem_we_q    <= bus.z80_we;
              mem_wdata_q <= bus.z80_wdata;
            end
            state <= ACC;
          end
        end
        ACC: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            if (owner_z80) begin
              z80_ack_q <= 1'b1;
              if (!mem_we_q) z80_rdata_q <= bus.mem_rdata;
            end else begin
              lcd_vld_q   <= 1'b1;
              lcd_rdata_q <= bus.mem_rdata;
            end
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.clk_ena   = clk_ena;
  assign bus.bus_ph    = bus_ph_q;
  assign bus.lcd_vld   = lcd_vld_q;
  assign bus.lcd_rdata = lcd_rdata_q;
  assign bus.z80_ack   = z80_ack_q;
  assign bus.z80_rdata = z80_rdata_q;
  assign bus.z80_wait  = bus.z80_req & ~z80_ack_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_z88_mem_sched.sv
// Self-checking bench for z88_mem_sched (CLK_DIV=4); a bench memory model answers mem_req.
module tb_z88_mem_sched;
  localparam int CLK_DIV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  z88_mem_sched_if bus();
  z88_mem_sched #(.CLK_DIV(CLK_DIV)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] lcd_q[$];
  logic [7:0] z80_q[$];
  logic [7:0] exp8;
  int         ack_delay = 0;
  bit         ack_tied = 1'b0;
  bit         data_from_addr = 1'b0;
  logic [7:0] rdata_val = 8'h00;
  int         acc_cnt = 0;

  // Memory model: ack on the (ack_delay+1)-th cycle of mem_req, or held high when tied.
  initial begin : mem_model
    forever begin
      @(negedge clk);
      if (bus.mem_req) acc_cnt++;
      else acc_cnt = 0;
      bus.mem_ack   = ack_tied | (bus.mem_req && acc_cnt > ack_delay);
      bus.mem_rdata = data_from_addr ? (bus.mem_addr[7:0] ^ 8'h5A) : rdata_val;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_ena(input logic ph);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.clk_ena && bus.bus_ph == ph) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL wait_ena: got no clk_ena with bus_ph=%0d want one within 40 clocks", ph);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.z80_req = 1'b1;
    #12;
    n_cmp++;
    if ({bus.clk_ena, bus.bus_ph, bus.lcd_vld, bus.z80_ack, bus.mem_req, bus.mem_we} !== 6'b0) begin
      n_bad++;
      $display("FAIL rst_ctrl: got %b want 000000",
               {bus.clk_ena, bus.bus_ph, bus.lcd_vld, bus.z80_ack, bus.mem_req, bus.mem_we});
    end
    n_cmp++;
    if ({bus.mem_addr, bus.mem_wdata, bus.lcd_rdata, bus.z80_rdata} !== 46'h0) begin
      n_bad++;
      $display("FAIL rst_data: got addr=%h wd=%h lr=%h zr=%h want all 0",
               bus.mem_addr, bus.mem_wdata, bus.lcd_rdata, bus.z80_rdata);
    end
    n_cmp++;
    if (bus.z80_wait !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_wait_hi: got %b want 1", bus.z80_wait);
    end
    bus.z80_req = 1'b0;
    #1;
    n_cmp++;
    if (bus.z80_wait !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_wait_lo: got %b want 0", bus.z80_wait);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++;
      if (bus.clk_ena !== ((i % CLK_DIV) == CLK_DIV - 1) ||
          bus.bus_ph !== (((i / CLK_DIV) % 2) == 1) || bus.mem_req !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_slots[%0d]: got ena=%b ph=%b req=%b want ena=%b ph=%b req=0", i,
                 bus.clk_ena, bus.bus_ph, bus.mem_req,
                 (i % CLK_DIV) == CLK_DIV - 1, ((i / CLK_DIV) % 2) == 1);
      end
    end
  endtask

  task automatic test_lcd_read;
    wait_ena(1'b1);
    ack_tied = 1'b1;
    rdata_val = 8'hA5;
    bus.lcd_rden = 1'b1;
    bus.lcd_addr = 22'h012345;
    lcd_q.push_back(8'hA5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      case (i)
        0: begin
          n_cmp++;
          if (bus.mem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL lcd_s0_req: got %b want 0", bus.mem_req);
          end
        end
        1: begin
          n_cmp++;
          if (bus.mem_req !== 1'b1 || bus.mem_addr !== 22'h012345 || bus.mem_we !== 1'b0) begin
            n_bad++;
            $display("FAIL lcd_s1_req: got req=%b addr=%h we=%b want 1 012345 0",
                     bus.mem_req, bus.mem_addr, bus.mem_we);
          end
          bus.lcd_rden = 1'b0;
        end
        2: begin
          n_cmp++;
          if (bus.lcd_vld !== 1'b1) begin
            n_bad++;
            $display("FAIL lcd_s2_vld: got %b want 1", bus.lcd_vld);
          end else if (lcd_q.size() == 0) begin
            n_bad++;
            $display("FAIL lcd_s2_sb: got vld with rdata %h want none queued", bus.lcd_rdata);
          end else begin
            exp8 = lcd_q.pop_front();
            n_cmp++;
            if (bus.lcd_rdata !== exp8) begin
              n_bad++;
              $display("FAIL lcd_rdata: got %h want %h", bus.lcd_rdata, exp8);
            end
          end
        end
        default: begin
          n_cmp++;
          if (bus.clk_ena !== 1'b1 || bus.lcd_vld !== 1'b0 || bus.mem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL lcd_s3: got ena=%b vld=%b req=%b want 1 0 0",
                     bus.clk_ena, bus.lcd_vld, bus.mem_req);
          end
        end
      endcase
    end
    ack_tied = 1'b0;
  endtask

  task automatic test_z80_write;
    int slot_len = 0;
    int acks = 0;
    int req_cycles = 0;
    wait_ena(1'b0);
    bus.z80_req = 1'b1;
    bus.z80_we = 1'b1;
    bus.z80_addr = 22'h000100;
    bus.z80_wdata = 8'h3C;
    ack_delay = 4;
    rdata_val = 8'hEE;
    z80_q.push_back(exp8_z80());
    for (int i = 0; i < 20 && slot_len == 0; i++) begin
      @(negedge clk);
      if (bus.mem_req) begin
        req_cycles++;
        n_cmp++;
        if (bus.mem_we !== 1'b1 || bus.mem_wdata !== 8'h3C || bus.mem_addr !== 22'h000100) begin
          n_bad++;
          $display("FAIL zw_hold[%0d]: got we=%b wd=%h addr=%h want 1 3c 000100",
                   i, bus.mem_we, bus.mem_wdata, bus.mem_addr);
        end
      end
      if (acks == 0 && !bus.z80_ack) begin
        n_cmp++;
        if (bus.z80_wait !== 1'b1) begin
          n_bad++;
          $display("FAIL zw_wait[%0d]: got %b want 1", i, bus.z80_wait);
        end
      end
      if (bus.z80_ack) begin
        acks++;
        exp8 = z80_q.size() ? z80_q.pop_front() : 8'hxx;
        n_cmp++;
        if (bus.z80_rdata !== exp8 || bus.z80_wait !== 1'b0) begin
          n_bad++;
          $display("FAIL zw_ack: got rdata=%h wait=%b want %h 0", bus.z80_rdata, bus.z80_wait, exp8);
        end
        bus.z80_req = 1'b0;
        bus.z80_we = 1'b0;
      end
      if (bus.clk_ena) slot_len = i + 1;
    end
    n_cmp++;
    if (slot_len != 8 || acks != 1 || req_cycles != 5) begin
      n_bad++;
      $display("FAIL zw_slot: got len=%0d acks=%0d req=%0d want 8 1 5", slot_len, acks, req_cycles);
    end
    ack_delay = 0;
  endtask

  logic [7:0] z80_shadow = 8'h00;
  function automatic logic [7:0] exp8_z80();
    return z80_shadow;
  endfunction

  task automatic test_z80_late;
    wait_ena(1'b1);
    bus.lcd_rden = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i >= 2 && i <= 4) begin
        n_cmp++;
        if (bus.mem_req !== 1'b0) begin
          n_bad++;
          $display("FAIL late_nogrant[%0d]: got req=%b want 0", i, bus.mem_req);
        end
      end
      if (i >= 3 && i <= 5) begin
        n_cmp++;
        if (bus.z80_wait !== 1'b1) begin
          n_bad++;
          $display("FAIL late_wait[%0d]: got %b want 1", i, bus.z80_wait);
        end
      end
      case (i)
        2: begin
          bus.z80_req = 1'b1;
          bus.z80_we = 1'b0;
          bus.z80_addr = 22'h02A5A5;
          rdata_val = 8'h5A;
          ack_delay = 0;
          z80_q.push_back(8'h5A);
          z80_shadow = 8'h5A;
        end
        3: begin
          n_cmp++;
          if (bus.clk_ena !== 1'b1 || bus.bus_ph !== 1'b0) begin
            n_bad++;
            $display("FAIL late_lcd_end: got ena=%b ph=%b want 1 0", bus.clk_ena, bus.bus_ph);
          end
        end
        5: begin
          n_cmp++;
          if (bus.mem_req !== 1'b1 || bus.mem_addr !== 22'h02A5A5 || bus.bus_ph !== 1'b1 ||
              bus.mem_we !== 1'b0) begin
            n_bad++;
            $display("FAIL late_grant: got req=%b addr=%h ph=%b we=%b want 1 02a5a5 1 0",
                     bus.mem_req, bus.mem_addr, bus.bus_ph, bus.mem_we);
          end
        end
        6: begin
          exp8 = z80_q.size() ? z80_q.pop_front() : 8'hxx;
          n_cmp++;
          if (bus.z80_ack !== 1'b1 || bus.z80_rdata !== exp8) begin
            n_bad++;
            $display("FAIL late_ack: got ack=%b rdata=%h want 1 %h", bus.z80_ack, bus.z80_rdata, exp8);
          end
          bus.z80_req = 1'b0;
        end
        7: begin
          n_cmp++;
          if (bus.clk_ena !== 1'b1) begin
            n_bad++;
            $display("FAIL late_z80_end: got ena=%b want 1", bus.clk_ena);
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_reset_mid;
    wait_ena(1'b1);
    bus.lcd_rden = 1'b1;
    bus.lcd_addr = 22'h00ABCD;
    ack_delay = 10;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.mem_req !== 1'b1) begin
      n_bad++;
      $display("FAIL rmid_req: got %b want 1", bus.mem_req);
    end
    bus.lcd_rden = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.mem_req !== 1'b0 || bus.lcd_rdata !== 8'h00 || bus.mem_addr !== 22'h0 || bus.clk_ena !== 1'b0) begin
      n_bad++;
      $display("FAIL rmid_clear: got req=%b lr=%h addr=%h ena=%b want 0 00 000000 0",
               bus.mem_req, bus.lcd_rdata, bus.mem_addr, bus.clk_ena);
    end
    lcd_q.delete();
    z80_shadow = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    ack_delay = 0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++;
      if (bus.lcd_vld !== 1'b0 || bus.z80_ack !== 1'b0 || bus.mem_req !== 1'b0 ||
          bus.clk_ena !== (i == 3 || i == 7) || bus.bus_ph !== (i >= 4 && i <= 7)) begin
        n_bad++;
        $display("FAIL rmid_after[%0d]: got vld=%b ack=%b req=%b ena=%b ph=%b", i,
                 bus.lcd_vld, bus.z80_ack, bus.mem_req, bus.clk_ena, bus.bus_ph);
      end
    end
  endtask

  task automatic test_reclaim;
    int ack_at = -1;
    logic ph_at = 1'bx;
    logic [21:0] addr_at = '0;
    wait_ena(1'b1);
    bus.lcd_rden = 1'b0;
    bus.z80_req = 1'b1;
    bus.z80_we = 1'b0;
    bus.z80_addr = 22'h3FFFFF;
    rdata_val = 8'hC3;
    ack_delay = 0;
    z80_q.push_back(8'hC3);
    z80_shadow = 8'hC3;
    for (int i = 0; i < 12 && ack_at < 0; i++) begin
      @(negedge clk);
      if (bus.z80_ack) begin
        ack_at = i;
        ph_at = bus.bus_ph;
        addr_at = bus.mem_addr;
        exp8 = z80_q.size() ? z80_q.pop_front() : 8'hxx;
        n_cmp++;
        if (bus.z80_rdata !== exp8) begin
          n_bad++;
          $display("FAIL reclaim_rdata: got %h want %h", bus.z80_rdata, exp8);
        end
        bus.z80_req = 1'b0;
      end
    end
    n_cmp++;
`ifdef Z80_SLOT_RECLAIM_EN
    if (ack_at != 2 || ph_at !== 1'b0 || addr_at !== 22'h3FFFFF) begin
      n_bad++;
      $display("FAIL reclaim_slot: got ack_at=%0d ph=%b addr=%h want 2 0 3fffff", ack_at, ph_at, addr_at);
    end
`else
    if (ack_at != 6 || ph_at !== 1'b1 || addr_at !== 22'h3FFFFF) begin
      n_bad++;
      $display("FAIL reclaim_slot: got ack_at=%0d ph=%b addr=%h want 6 1 3fffff", ack_at, ph_at, addr_at);
    end
`endif
  endtask

  task automatic test_back_to_back;
    int n_vld = 0;
    int n_ack = 0;
    wait_ena(1'b1);
    data_from_addr = 1'b1;
    ack_delay = 1;
    bus.lcd_rden = 1'b1;
    bus.lcd_addr = 22'h000011;
    bus.z80_req = 1'b1;
    bus.z80_we = 1'b0;
    bus.z80_addr = 22'h000022;
    lcd_q.push_back(8'h4B);
    lcd_q.push_back(8'h69);
    z80_q.push_back(8'h78);
    z80_shadow = 8'h78;
    for (int i = 0; i < 30 && !(n_vld == 2 && n_ack == 1); i++) begin
      @(negedge clk);
      if (bus.lcd_vld) begin
        n_vld++;
        exp8 = lcd_q.size() ? lcd_q.pop_front() : 8'hxx;
        n_cmp++;
        if (bus.lcd_rdata !== exp8) begin
          n_bad++;
          $display("FAIL b2b_lcd[%0d]: got %h want %h", n_vld, bus.lcd_rdata, exp8);
        end
        if (n_vld == 1) bus.lcd_addr = 22'h000033;
        else bus.lcd_rden = 1'b0;
      end
      if (bus.z80_ack) begin
        n_ack++;
        exp8 = z80_q.size() ? z80_q.pop_front() : 8'hxx;
        n_cmp++;
        if (bus.z80_rdata !== exp8) begin
          n_bad++;
          $display("FAIL b2b_z80: got %h want %h", bus.z80_rdata, exp8);
        end
        bus.z80_req = 1'b0;
      end
    end
    n_cmp++;
    if (n_vld != 2 || n_ack != 1 || lcd_q.size() != 0 || z80_q.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_count: got vld=%0d ack=%0d lq=%0d zq=%0d want 2 1 0 0",
               n_vld, n_ack, lcd_q.size(), z80_q.size());
    end
    bus.lcd_rden = 1'b0;
    data_from_addr = 1'b0;
    ack_delay = 0;
  endtask

  initial begin : main
    bus.lcd_rden = 1'b0;
    bus.lcd_addr = '0;
    bus.z80_req = 1'b0;
    bus.z80_we = 1'b0;
    bus.z80_addr = '0;
    bus.z80_wdata = '0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    test_reset();
    test_lcd_read();
    test_z80_write();
    test_z80_late();
    test_reset_mid();
    test_reclaim();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
